// File: rtl/hwpe_ctrl_job_sched_pkg.sv
// Shared types and helpers for the HWPE job scheduler.
// Holds the FSM state encoding, the default-configuration queue
// entry layout and a wrap-around increment helper.
package hwpe_ctrl_job_sched_pkg;

    // Default configuration: 4 cores, 4-bit tags.
    localparam int unsigned JS_N_CORES   = 4;
    localparam int unsigned JS_TAG_WIDTH = 4;
    localparam int unsigned JS_CORE_ID_W = $clog2(JS_N_CORES);

    // Sequencing FSM encoding.
    typedef logic [1:0] job_sched_state_t;
    localparam job_sched_state_t ST_IDLE  = 2'd0;
    localparam job_sched_state_t ST_START = 2'd1;
    localparam job_sched_state_t ST_RUN   = 2'd2;

    // One queued job in the default configuration: owner and engine tag.
    typedef struct packed {
        logic [JS_CORE_ID_W-1:0] core_id;
        logic [JS_TAG_WIDTH-1:0] tag;
    } job_entry_t;

    // (v + 1) mod n, for pointers whose range need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning upward
// (with wrap) from an internal pointer. The pointer moves to the slot after
// the granted index whenever the caller commits the grant via upd_i.
module hwpe_ctrl_rr_arbiter
    import hwpe_ctrl_job_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             en_i,
    input  logic             upd_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;
    int unsigned      sum;

    // Scan requesters starting at the pointer; first hit wins.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        sum   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sum = 32'(ptr_q) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = IDX_W'(sum);
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    // Advance the pointer past the winner when the grant is taken.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (clear_i) begin
            ptr_q <= '0;
        end else if (upd_i) begin
            ptr_q <= IDX_W'(wrap_inc(32'(idx_o), N_REQ));
        end
    end

endmodule

// File: rtl/hwpe_ctrl_job_sched.sv
// Job scheduler in front of an HWPE engine.
// Cores enqueue jobs through a round-robin arbiter into a small FIFO; a
// three-state FSM (IDLE/START/RUN) issues one start per job, waits for the
// engine's done and returns a one-cycle completion event to the owner.
// Optional macro HWPE_CTRL_JOB_SCHED_TIMEOUT_EN adds a RUN watchdog that
// aborts a job after TIMEOUT_CYCLES cycles and pulses err_o.
module hwpe_ctrl_job_sched
    import hwpe_ctrl_job_sched_pkg::*;
#(
    parameter int unsigned N_CORES        = 4,
    parameter int unsigned N_JOBS         = 2,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic [N_CORES-1:0]                 req_i,
    input  logic [N_CORES-1:0][TAG_WIDTH-1:0]  tag_i,
    output logic [N_CORES-1:0]                 gnt_o,
    output logic                               start_o,
    output logic [TAG_WIDTH-1:0]               tag_o,
    input  logic                               done_i,
    output logic                               busy_o,
    output logic                               full_o,
    output logic [$clog2(N_JOBS):0]            pending_o,
    output logic [N_CORES-1:0]                 evt_o,
    output logic                               err_o
);

    localparam int unsigned CID_W = $clog2(N_CORES);
    localparam int unsigned PTR_W = (N_JOBS > 1) ? $clog2(N_JOBS) : 1;
    localparam int unsigned CNT_W = $clog2(N_JOBS) + 1;

    typedef struct packed {
        logic [CID_W-1:0]     core_id;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t             mem_q [N_JOBS];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    job_sched_state_t   state_q, state_d;
    entry_t             cur_q;
    logic [N_CORES-1:0] evt_q, evt_d;
    logic               tmo_hit;

    logic               arb_en;
    logic [N_CORES-1:0] gnt;
    logic [CID_W-1:0]   gnt_idx;
    logic               push, pop;

    // Admission is decided on the registered count, so a pop this cycle
    // never frees a slot for this cycle's push.
    assign arb_en = !clear_i && (count_q < CNT_W'(N_JOBS));
    assign push   = |gnt;

    // IDLE holds off for the cycle the completion event is presented, which
    // places the next start two cycles after evt_o.
    assign pop = (state_q == ST_IDLE) && (count_q != '0) && (evt_q == '0) && !clear_i;

    hwpe_ctrl_rr_arbiter #(
        .N_REQ (N_CORES)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .req_i   (req_i),
        .en_i    (arb_en),
        .upd_i   (push),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    // Queue storage: write the granted core's id and tag.
    // NOTE: the entry array is not reset; validity is tracked by the pointers and count, which are reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{core_id: gnt_idx, tag: tag_i[gnt_idx]};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= PTR_W'(wrap_inc(32'(wr_ptr_q), N_JOBS));
            end
            if (pop) begin
                rd_ptr_q <= PTR_W'(wrap_inc(32'(rd_ptr_q), N_JOBS));
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state and completion-event decode; done beats the watchdog.
    always_comb begin
        state_d = state_q;
        evt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (done_i || tmo_hit) begin
                    state_d              = ST_IDLE;
                    evt_d[cur_q.core_id] = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, current job latch and registered completion event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            evt_q   <= '0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
            if (pop) begin
                cur_q <= mem_q[rd_ptr_q];
            end
        end
    end

`ifdef HWPE_CTRL_JOB_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_q;

    assign tmo_hit = (state_q == ST_RUN) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: zeroed while in START, counts every RUN cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (clear_i || (state_q == ST_START)) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Abort flag pulses alongside evt_o only when done did not arrive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (clear_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_hit && !done_i;
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign gnt_o     = gnt;
    assign start_o   = (state_q == ST_START);
    assign busy_o    = (state_q == ST_START) || (state_q == ST_RUN);
    assign tag_o     = cur_q.tag;
    assign full_o    = (count_q == CNT_W'(N_JOBS));
    assign pending_o = count_q;
    assign evt_o     = evt_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_sched.sv
// Directed testbench for hwpe_ctrl_job_sched (N_CORES=4, N_JOBS=2,
// TAG_WIDTH=4, TIMEOUT_CYCLES=8). Inputs change 1ns after the rising edge;
// outputs are sampled on the falling edge of the same cycle.
module tb_hwpe_ctrl_job_sched;

    localparam int N_CORES        = 4;
    localparam int N_JOBS         = 2;
    localparam int TAG_WIDTH      = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic                              clk_i = 1'b0;
    logic                              rst_ni = 1'b0;
    logic                              clear_i = 1'b0;
    logic [N_CORES-1:0]                req_i = '0;
    logic [N_CORES-1:0][TAG_WIDTH-1:0] tag_i = '0;
    logic                              done_i = 1'b0;
    logic [N_CORES-1:0]                gnt_o;
    logic                              start_o;
    logic [TAG_WIDTH-1:0]              tag_o;
    logic                              busy_o;
    logic                              full_o;
    logic [$clog2(N_JOBS):0]           pending_o;
    logic [N_CORES-1:0]                evt_o;
    logic                              err_o;

    int n_checks = 0;
    int n_fail   = 0;

    hwpe_ctrl_job_sched #(
        .N_CORES        (N_CORES),
        .N_JOBS         (N_JOBS),
        .TAG_WIDTH      (TAG_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .req_i     (req_i),
        .tag_i     (tag_i),
        .gnt_o     (gnt_o),
        .start_o   (start_o),
        .tag_o     (tag_o),
        .done_i    (done_i),
        .busy_o    (busy_o),
        .full_o    (full_o),
        .pending_o (pending_o),
        .evt_o     (evt_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        req_i   = '0;
        tag_i   = '0;
        done_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_i  = '0;
        #2;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
        n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start_o); end
        n_checks++; if (tag_o !== 4'h0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", tag_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full_o); end
        n_checks++; if (pending_o !== 2'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending_o); end
        n_checks++; if (evt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_evt: got %b want 0000", evt_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    endtask

    // Grant at 0, start at 2, done at 10, event at 11.
    task automatic test_single_job();
        apply_reset();
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            req_i    = (c == 0) ? 4'b0010 : 4'b0000;
            tag_i[1] = 4'd3;
            done_i   = (c == 10);
            @(negedge clk_i);
            case (c)
                0: begin
                    n_checks++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL single_gnt: got %b want 0010", gnt_o); end
                    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_c0: got %b want 0", busy_o); end
                end
                1: begin
                    n_checks++; if (pending_o !== 2'd1) begin n_fail++; $display("FAIL single_pending_c1: got %0d want 1", pending_o); end
                    n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL single_start_c1: got %b want 0", start_o); end
                end
                2: begin
                    n_checks++; if (start_o !== 1'b1) begin n_fail++; $display("FAIL single_start_c2: got %b want 1", start_o); end
                    n_checks++; if (tag_o !== 4'd3) begin n_fail++; $display("FAIL single_tag: got %0d want 3", tag_o); end
                    n_checks++; if (pending_o !== 2'd0) begin n_fail++; $display("FAIL single_pending_c2: got %0d want 0", pending_o); end
                end
                3: begin
                    n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL single_start_c3: got %b want 0", start_o); end
                    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy_c3: got %b want 1", busy_o); end
                end
                10: begin
                    n_checks++; if (evt_o !== 4'b0000) begin n_fail++; $display("FAIL single_evt_c10: got %b want 0000", evt_o); end
                    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy_c10: got %b want 1", busy_o); end
                end
                11: begin
                    n_checks++; if (evt_o !== 4'b0010) begin n_fail++; $display("FAIL single_evt_c11: got %b want 0010", evt_o); end
                    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_c11: got %b want 0", busy_o); end
                end
                12: begin
                    n_checks++; if (evt_o !== 4'b0000) begin n_fail++; $display("FAIL single_evt_c12: got %b want 0000", evt_o); end
                end
                default: ;
            endcase
        end
    endtask

    // All four cores request; granted cores drop req. Engine never done.
    task automatic test_contention();
        logic [3:0] req_tab  [5];
        logic [3:0] gnt_exp  [5];
        logic       full_exp [5];
        logic [1:0] pend_exp [5];
        req_tab  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b1000};
        gnt_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
        full_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        pend_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            req_i = req_tab[c];
            tag_i = {4'hD, 4'hC, 4'hB, 4'hA};
            @(negedge clk_i);
            n_checks++; if (gnt_o !== gnt_exp[c]) begin n_fail++; $display("FAIL contention_gnt c%0d: got %b want %b", c, gnt_o, gnt_exp[c]); end
            n_checks++; if (full_o !== full_exp[c]) begin n_fail++; $display("FAIL contention_full c%0d: got %b want %b", c, full_o, full_exp[c]); end
            n_checks++; if (pending_o !== pend_exp[c]) begin n_fail++; $display("FAIL contention_pending c%0d: got %0d want %0d", c, pending_o, pend_exp[c]); end
            if (c == 2) begin
                n_checks++; if (start_o !== 1'b1) begin n_fail++; $display("FAIL contention_start: got %b want 1", start_o); end
                n_checks++; if (tag_o !== 4'hA) begin n_fail++; $display("FAIL contention_tag: got %h want a", tag_o); end
            end
        end
    endtask

    // Continues from test_contention: core0 running, core1/core2 queued,
    // core3 requesting. Pop at b2 must not admit core3 until b3.
    task automatic test_full_boundary();
        for (int b = 0; b < 5; b++) begin
            next_cycle();
            done_i = (b == 0);
            req_i  = (b < 4) ? 4'b1000 : 4'b0000;
            @(negedge clk_i);
            case (b)
                0: begin
                    n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL full_gnt_b0: got %b want 0000", gnt_o); end
                end
                1: begin
                    n_checks++; if (evt_o !== 4'b0001) begin n_fail++; $display("FAIL full_evt_b1: got %b want 0001", evt_o); end
                    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_busy_b1: got %b want 0", busy_o); end
                    n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL full_gnt_b1: got %b want 0000", gnt_o); end
                end
                2: begin
                    n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL full_gnt_on_pop: got %b want 0000", gnt_o); end
                    n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL full_full_b2: got %b want 1", full_o); end
                end
                3: begin
                    n_checks++; if (gnt_o !== 4'b1000) begin n_fail++; $display("FAIL full_gnt_b3: got %b want 1000", gnt_o); end
                    n_checks++; if (start_o !== 1'b1) begin n_fail++; $display("FAIL full_start_b3: got %b want 1", start_o); end
                    n_checks++; if (tag_o !== 4'hB) begin n_fail++; $display("FAIL full_tag_b3: got %h want b", tag_o); end
                    n_checks++; if (pending_o !== 2'd1) begin n_fail++; $display("FAIL full_pending_b3: got %0d want 1", pending_o); end
                end
                4: begin
                    n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL full_full_b4: got %b want 1", full_o); end
                    n_checks++; if (pending_o !== 2'd2) begin n_fail++; $display("FAIL full_pending_b4: got %0d want 2", pending_o); end
                end
                default: ;
            endcase
        end
        done_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] req_a [2];
        logic [3:0] exp_a [2];
        logic [3:0] req_b [3];
        logic [3:0] exp_b [3];
        req_a = '{4'b0010, 4'b0011};
        exp_a = '{4'b0010, 4'b0001};
        req_b = '{4'b1000, 4'b1010, 4'b1000};
        exp_b = '{4'b1000, 4'b0010, 4'b1000};
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            req_i = req_a[c];
            @(negedge clk_i);
            n_checks++; if (gnt_o !== exp_a[c]) begin n_fail++; $display("FAIL rr_a_gnt c%0d: got %b want %b", c, gnt_o, exp_a[c]); end
        end
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            req_i = req_b[c];
            @(negedge clk_i);
            n_checks++; if (gnt_o !== exp_b[c]) begin n_fail++; $display("FAIL rr_wrap_gnt c%0d: got %b want %b", c, gnt_o, exp_b[c]); end
        end
    endtask

    task automatic test_clear();
        logic [3:0] req_tab [7];
        req_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            req_i   = req_tab[c];
            clear_i = (c == 3) || (c == 4);
            done_i  = (c == 5);
            @(negedge clk_i);
            case (c)
                3: begin
                    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL clear_busy_before: got %b want 1", busy_o); end
                    n_checks++; if (pending_o !== 2'd2) begin n_fail++; $display("FAIL clear_pending_before: got %0d want 2", pending_o); end
                end
                4: begin
                    n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL clear_gnt_forced: got %b want 0000", gnt_o); end
                    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_busy_after: got %b want 0", busy_o); end
                    n_checks++; if (pending_o !== 2'd0) begin n_fail++; $display("FAIL clear_pending_after: got %0d want 0", pending_o); end
                end
                5: begin
                    n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL clear_start_c5: got %b want 0", start_o); end
                    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_busy_c5: got %b want 0", busy_o); end
                end
                6: begin
                    n_checks++; if (evt_o !== 4'b0000) begin n_fail++; $display("FAIL clear_evt_after_done: got %b want 0000", evt_o); end
                    n_checks++; if (pending_o !== 2'd0) begin n_fail++; $display("FAIL clear_pending_c6: got %0d want 0", pending_o); end
                end
                default: ;
            endcase
        end
        clear_i = 1'b0;
        done_i  = 1'b0;
    endtask

    // Job A (core0, tag 5) enters RUN at cycle 3 and never gets done;
    // job B (core2, tag 7) is queued behind it.
    task automatic test_timeout();
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            req_i    = (c == 0) ? 4'b0001 : ((c == 1) ? 4'b0100 : 4'b0000);
            tag_i[0] = 4'd5;
            tag_i[2] = 4'd7;
            @(negedge clk_i);
            case (c)
                10: begin
                    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_err_c10: got %b want 0", err_o); end
                    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_c10: got %b want 1", busy_o); end
                end
`ifdef HWPE_CTRL_JOB_SCHED_TIMEOUT_EN
                11: begin
                    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_err_c11: got %b want 1", err_o); end
                    n_checks++; if (evt_o !== 4'b0001) begin n_fail++; $display("FAIL tmo_evt_c11: got %b want 0001", evt_o); end
                    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_c11: got %b want 0", busy_o); end
                end
                12: begin
                    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_err_c12: got %b want 0", err_o); end
                    n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL tmo_start_c12: got %b want 0", start_o); end
                end
                13: begin
                    n_checks++; if (start_o !== 1'b1) begin n_fail++; $display("FAIL tmo_start_c13: got %b want 1", start_o); end
                    n_checks++; if (tag_o !== 4'd7) begin n_fail++; $display("FAIL tmo_tag_c13: got %0d want 7", tag_o); end
                end
`else
                11: begin
                    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL notmo_err_c11: got %b want 0", err_o); end
                    n_checks++; if (evt_o !== 4'b0000) begin n_fail++; $display("FAIL notmo_evt_c11: got %b want 0000", evt_o); end
                end
                13: begin
                    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL notmo_busy_c13: got %b want 1", busy_o); end
                    n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL notmo_start_c13: got %b want 0", start_o); end
                    n_checks++; if (tag_o !== 4'd5) begin n_fail++; $display("FAIL notmo_tag_c13: got %0d want 5", tag_o); end
                end
`endif
                default: ;
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_contention();
        test_full_boundary();
        test_round_robin();
        test_clear();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
